// File: rtl/pe_act_feeder.sv
// Activation feeder: walks conv windows through the ifmap SRAM and streams each
// word to PE0, with valid/final strobes skewed one cycle per PE along the row.
module pe_act_feeder #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 64,
  parameter int ROW_WORDS = 12,
  parameter int KROWS     = 3,
  parameter int ROW_PITCH = 264,
  parameter int WIN_STEP  = 4,
  parameter int NUM_WIN   = 4,
  parameter int NUM_PE    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] act_out,
  output logic              valid_out,
  output logic              final_out,
  output logic [NUM_PE-1:0] valid_skew,
  output logic [NUM_PE-1:0] final_skew,
  output logic              busy,
  output logic              done
);

  localparam int WORD_W = $clog2(ROW_WORDS + 1);
  localparam int ROW_W  = $clog2(KROWS + 1);
  localparam int WIN_W  = $clog2(NUM_WIN + 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(ROW_WORDS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(KROWS - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(NUM_WIN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               issue_s, win_end_s, run_end_s;
  logic [ADDR_W-1:0]  addr_s;
  logic               rd_en_q, rd_fin_q, rd_last_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               s1_v_q, s1_f_q, s1_l_q, lst_q;
  logic [DATA_W-1:0]  act_q;
  logic [NUM_PE-1:0]  vsk_q, fsk_q;

  assign win_end_s = (word_q == WORD_LAST) && (row_q == ROW_LAST);
  assign run_end_s = win_end_s && (win_q == WIN_LAST);
  // Address math is done in ADDR_W bits so it wraps modulo the SRAM size.
  assign addr_s = base_q + ADDR_W'(win_q) * ADDR_W'(WIN_STEP)
                + ADDR_W'(row_q) * ADDR_W'(ROW_PITCH) + ADDR_W'(word_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN; else state_d = S_IDLE;
      S_RUN:   if (issue_s && run_end_s) state_d = S_DRAIN; else state_d = S_RUN;
      S_DRAIN: if (lst_q) state_d = S_DONE; else state_d = S_DRAIN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue_s = (state_q == S_RUN) && !hold;
    busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    done    = (state_q == S_DONE);
  end

  // Window walk: word innermost, then kernel row, then window.
  always_comb begin
    base_d = base_q;
    word_d = word_q;
    row_d  = row_q;
    win_d  = win_q;
    if ((state_q == S_IDLE) && start) begin
      base_d = base_addr;
      word_d = '0;
      row_d  = '0;
      win_d  = '0;
    end else if (issue_s) begin
      if (word_q == WORD_LAST) begin
        word_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
          if (win_q == WIN_LAST) win_d = '0;
          else                   win_d = win_q + WIN_W'(1);
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        word_d = word_q + WORD_W'(1);
      end
    end else begin
      base_d = base_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      word_q <= '0;
      row_q  <= '0;
      win_q  <= '0;
    end else begin
      base_q <= base_d;
      word_q <= word_d;
      row_q  <= row_d;
      win_q  <= win_d;
    end
  end

  // Tags ride alongside the read: issue -> SRAM data cycle -> PE0 output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en_q   <= 1'b0;
      rd_fin_q  <= 1'b0;
      rd_last_q <= 1'b0;
      addr_q    <= '0;
      s1_v_q    <= 1'b0;
      s1_f_q    <= 1'b0;
      s1_l_q    <= 1'b0;
      lst_q     <= 1'b0;
      act_q     <= '0;
      vsk_q     <= '0;
      fsk_q     <= '0;
    end else begin
      rd_en_q   <= issue_s;
      rd_fin_q  <= issue_s && win_end_s;
      rd_last_q <= issue_s && run_end_s;
      addr_q    <= issue_s ? addr_s : addr_q;
      s1_v_q    <= rd_en_q;
      s1_f_q    <= rd_fin_q;
      s1_l_q    <= rd_last_q;
      lst_q     <= s1_l_q;
      act_q     <= s1_v_q ? sram_rdata : act_q;
      vsk_q     <= {vsk_q[NUM_PE-2:0], s1_v_q};
      fsk_q     <= {fsk_q[NUM_PE-2:0], s1_f_q};
    end
  end

  assign sram_rd_en = rd_en_q;
  assign sram_addr  = addr_q;
  assign act_out    = act_q;
  assign valid_out  = vsk_q[0];
  assign final_out  = fsk_q[0];
  assign valid_skew = vsk_q;
  assign final_skew = fsk_q;

endmodule

// File: tb/tb_pe_act_feeder.sv
// Bench for pe_act_feeder: per-cycle comparison against a queue-based model of
// the window walk, plus literal timing/address pins and randomized hold/start runs.
module tb_pe_act_feeder;

  localparam int AW = 11;
  localparam int DW = 64;
  localparam int NPE = 8;

  logic            clk = 1'b0;
  logic            reset, start, hold;
  logic [AW-1:0]   base_addr;
  logic [DW-1:0]   sram_rdata;
  logic            sram_rd_en, valid_out, final_out, busy, done;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   act_out;
  logic [NPE-1:0]  valid_skew, final_skew;

  always #5 clk = ~clk;

  pe_act_feeder dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .hold(hold),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .act_out(act_out), .valid_out(valid_out), .final_out(final_out),
    .valid_skew(valid_skew), .final_skew(final_skew), .busy(busy), .done(done)
  );

  function automatic logic [63:0] mem_f(input logic [10:0] a);
    return {a, 5'd0, ~a, 5'd9, a ^ 11'h5A5, 5'd3, a + 11'd7, 5'd1};
  endfunction

  // SRAM: one-cycle read latency, junk on the bus when not reading
  always @(posedge clk) begin
    if (sram_rd_en) sram_rdata <= mem_f(sram_addr);
    else            sram_rdata <= {$urandom, $urandom};
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Behavioural model state
  logic [10:0] rq_a[$];
  logic        rq_f[$];
  logic        rq_l[$];
  logic        p1_v = 1'b0, p1_f = 1'b0, p1_l = 1'b0, p2_v = 1'b0, p2_f = 1'b0, p2_l = 1'b0;
  logic [10:0] p1_a = '0, p2_a = '0;
  logic        e_rd = 1'b0, e_v = 1'b0, e_f = 1'b0, e_last = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic [10:0] e_addr = '0;
  logic [63:0] e_act = '0;
  logic [7:0]  e_vsk = '0, e_fsk = '0;
  logic        nd, acc, iss;

  // Observation log
  int nrd, nbeats, nfin, ndone, nbusy, first_rd, last_rd, first_v, last_v, done_cyc, sk7_rise, fsk7_last;
  int fin_beats[$];
  logic [10:0] rd_addrs[$];
  logic [10:0] addrs_a[$];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, a, e);
    end
  endtask

  task automatic lit(input string nm, input int a, input int e);
    n_vec++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", nm, a, e);
    end
  endtask

  task automatic build(input logic [10:0] b);
    rq_a.delete(); rq_f.delete(); rq_l.delete();
    for (int w = 0; w < 4; w++)
      for (int r = 0; r < 3; r++)
        for (int x = 0; x < 12; x++) begin
          rq_a.push_back(11'(int'(b) + w * 4 + r * 264 + x));
          rq_f.push_back(r == 2 && x == 11);
          rq_l.push_back(r == 2 && x == 11 && w == 3);
        end
  endtask

  task automatic model_step();
    if (reset) begin
      rq_a.delete(); rq_f.delete(); rq_l.delete();
      p1_v = 1'b0; p2_v = 1'b0; e_rd = 1'b0; e_v = 1'b0; e_f = 1'b0; e_last = 1'b0;
      e_busy = 1'b0; e_done = 1'b0; e_act = '0; e_vsk = '0; e_fsk = '0;
    end else begin
      nd = e_last;
      e_v = p2_v;
      e_f = p2_v && p2_f;
      e_last = p2_v && p2_l;
      if (p2_v) e_act = mem_f(p2_a);
      e_vsk = {e_vsk[6:0], e_v};
      e_fsk = {e_fsk[6:0], e_f};
      p2_v = p1_v; p2_a = p1_a; p2_f = p1_f; p2_l = p1_l;
      acc = !e_busy && !e_done && start;
      iss = e_busy && !hold && (rq_a.size() > 0);
      e_rd = iss;
      p1_v = iss;
      if (iss) begin
        p1_a = rq_a.pop_front();
        p1_f = rq_f.pop_front();
        p1_l = rq_l.pop_front();
        e_addr = p1_a;
      end
      if (acc) begin
        e_busy = 1'b1;
        build(base_addr);
      end
      e_done = nd;
      if (nd) e_busy = 1'b0;
    end
  endtask

  task automatic clr_log();
    nrd = 0; nbeats = 0; nfin = 0; ndone = 0; nbusy = 0;
    first_rd = -1; last_rd = -1; first_v = -1; last_v = -1; done_cyc = -1;
    sk7_rise = -1; fsk7_last = -1;
    fin_beats.delete(); rd_addrs.delete();
  endtask

  // Model step and comparison on every falling edge
  initial begin
    clr_log();
    forever begin
      @(negedge clk);
      cyc++;
      model_step();
      chk("rd_en", 64'(sram_rd_en), 64'(e_rd));
      if (e_rd) chk("addr", 64'(sram_addr), 64'(e_addr));
      chk("valid_out", 64'(valid_out), 64'(e_v));
      chk("final_out", 64'(final_out), 64'(e_f));
      chk("act_out", act_out, e_act);
      chk("valid_skew", 64'(valid_skew), 64'(e_vsk));
      chk("final_skew", 64'(final_skew), 64'(e_fsk));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      if (sram_rd_en) begin
        nrd++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        rd_addrs.push_back(sram_addr);
      end
      if (valid_out) begin
        nbeats++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (final_out) begin
          nfin++;
          fin_beats.push_back(nbeats);
        end
      end
      if (done) begin ndone++; done_cyc = cyc; end
      if (busy) nbusy++;
      if (valid_skew[7] && sk7_rise < 0) sk7_rise = cyc;
      if (final_skew[7]) fsk7_last = cyc;
    end
  end

  task automatic start_run(input logic [10:0] b, output int k);
    @(negedge clk); #2;
    clr_log();
    base_addr = b;
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (ndone > 0) break;
    end
    lit("done_seen", (ndone > 0) ? 1 : 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k, mm;
    reset = 1'b1; start = 1'b0; hold = 1'b0; base_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    lit("reset_idle", int'({sram_rd_en, valid_out, final_out, busy, done}), 0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);

    // Default run, base 0
    start_run(11'd0, k);
    wait_done(400);
    repeat (12) @(negedge clk);
    #1;
    lit("first_rd", first_rd, k + 1);
    lit("last_rd", last_rd, k + 144);
    lit("num_rd", nrd, 144);
    lit("first_valid", first_v, k + 3);
    lit("last_valid", last_v, k + 146);
    lit("done_cyc", done_cyc, k + 147);
    lit("beats", nbeats, 144);
    lit("finals", nfin, 4);
    lit("fin_beat0", fin_beats[0], 36);
    lit("fin_beat1", fin_beats[1], 72);
    lit("fin_beat2", fin_beats[2], 108);
    lit("fin_beat3", fin_beats[3], 144);
    lit("addr11", int'(rd_addrs[11]), 11);
    lit("addr12", int'(rd_addrs[12]), 264);
    lit("addr24", int'(rd_addrs[24]), 528);
    lit("addr35", int'(rd_addrs[35]), 539);
    lit("addr36", int'(rd_addrs[36]), 4);
    lit("addr143", int'(rd_addrs[143]), 551);
    lit("vsk7_rise", sk7_rise, k + 10);
    lit("fsk7_fall", fsk7_last + 1, k + 154);
    addrs_a = rd_addrs;

    // Same run with a 5-cycle hold mid-row
    start_run(11'd0, k);
    repeat (4) @(negedge clk);
    #2 hold = 1'b1;
    repeat (5) @(negedge clk);
    #2 hold = 1'b0;
    wait_done(400);
    repeat (3) @(negedge clk);
    #1;
    mm = 0;
    for (int i = 0; i < 144; i++) if (rd_addrs[i] !== addrs_a[i]) mm++;
    lit("hold_addr_seq", mm, 0);
    lit("hold_num_rd", nrd, 144);
    lit("hold_beats", nbeats, 144);
    lit("hold_valid_span", last_v - first_v + 1, 149);
    lit("hold_done_cyc", done_cyc, k + 152);

    // Address wrap
    start_run(11'd2040, k);
    wait_done(400);
    repeat (3) @(negedge clk);
    #1;
    lit("wrap_addr0", int'(rd_addrs[0]), 2040);
    lit("wrap_addr7", int'(rd_addrs[7]), 2047);
    lit("wrap_addr8", int'(rd_addrs[8]), 0);
    lit("wrap_addr12", int'(rd_addrs[12]), 256);

    // Reset mid-run at beat 50
    start_run(11'd0, k);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (nbeats >= 50) break;
    end
    lit("beat50_reached", (nbeats >= 50) ? 1 : 0, 1);
    #1 reset = 1'b1;
    #1;
    lit("rst_strobes", int'({sram_rd_en, valid_out, final_out, busy, done}), 0);
    lit("rst_skew", int'({valid_skew, final_skew}), 0);
    lit("rst_addr", int'(sram_addr), 0);
    lit("rst_act", (act_out == '0) ? 1 : 0, 1);
    @(negedge clk); #2;
    reset = 1'b0;
    clr_log();
    repeat (20) @(negedge clk);
    #1;
    lit("post_rst_busy", nbusy, 0);
    lit("post_rst_rd", nrd, 0);
    lit("post_rst_done", ndone, 0);

    // Start during RUN and during DONE is ignored
    start_run(11'd0, k);
    repeat (20) @(negedge clk);
    #2 base_addr = 11'd100; start = 1'b1;
    @(negedge clk);
    #2 start = 1'b0;
    for (int i = 0; i < 400 && cyc < k + 147; i++) begin
      @(negedge clk); #1;
    end
    #1 start = 1'b1;
    @(negedge clk);
    #2 start = 1'b0;
    repeat (160) @(negedge clk);
    #1;
    lit("ign_done_cyc", done_cyc, k + 147);
    lit("ign_done_count", ndone, 1);
    lit("ign_beats", nbeats, 144);
    lit("ign_addr0", int'(rd_addrs[0]), 0);

    // Randomized base, hold and stray start pulses
    for (int r = 0; r < 6; r++) begin
      start_run(11'($urandom_range(0, 2047)), k);
      for (int i = 0; i < 700; i++) begin
        @(negedge clk); #2;
        if (ndone > 0) break;
        hold  = ($urandom_range(0, 4) == 0);
        start = ($urandom_range(0, 15) == 0);
      end
      start = 1'b0;
      hold = 1'b0;
      lit("rnd_done_seen", (ndone > 0) ? 1 : 0, 1);
      repeat (4) @(negedge clk);
      #1;
      lit("rnd_beats", nbeats, 144);
      lit("rnd_finals", nfin, 4);
      lit("rnd_done_count", ndone, 1);
    end

    repeat (5) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe_act_feeder.md
PE_ACT_FEEDER -- requirements
Module: pe_act_feeder

Interface
REQ-001 Parameter ADDR_W, default 11, sets the SRAM word address width.
REQ-002 Parameter DATA_W, default 64, sets the activation word width (8 lanes x 8 bits).
REQ-003 Parameter ROW_WORDS, default 12, is the number of words per kernel row (3 columns x 4 channel-words).
REQ-004 Parameter KROWS, default 3, is the number of kernel rows per window.
REQ-005 Parameter ROW_PITCH, default 264, is the address distance between ifmap rows (66 columns x 4 words).
REQ-006 Parameter WIN_STEP, default 4, is the address step between horizontally adjacent windows.
REQ-007 Parameter NUM_WIN, default 4, is the number of windows per run.
REQ-008 Parameter NUM_PE, default 8, is the number of PEs in the systolic row.
REQ-009 Port clk, input, 1 bit, is the single clock; all logic is rising-edge.
REQ-010 Port reset, input, 1 bit, is the asynchronous active-high reset.
REQ-011 Port start, input, 1 bit, is a run request pulse.
REQ-012 Port base_addr, input, ADDR_W bits, is the first-window origin, latched on an accepted start.
REQ-013 Port hold, input, 1 bit, is a downstream back-pressure signal.
REQ-014 Port sram_rd_en, output, 1 bit, is the ifmap SRAM read strobe.
REQ-015 Port sram_addr, output, ADDR_W bits, is the ifmap SRAM read address.
REQ-016 Port sram_rdata, input, DATA_W bits, is the SRAM read data, valid one cycle after sram_rd_en.
REQ-017 Port act_out, output, DATA_W bits, is the activation word sent to PE0.
REQ-018 Port valid_out, output, 1 bit, qualifies act_out for PE0.
REQ-019 Port final_out, output, 1 bit, marks the last beat of a window for PE0.
REQ-020 Port valid_skew, output, NUM_PE bits, carries valid_out delayed by i cycles on bit i.
REQ-021 Port final_skew, output, NUM_PE bits, carries final_out delayed by i cycles on bit i.
REQ-022 Port busy, output, 1 bit, is high while a run is in progress.
REQ-023 Port done, output, 1 bit, is a one-cycle pulse at the end of a run.

Function
REQ-024 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-025 The FSM SHALL move IDLE->RUN when start=1, latching base_addr and clearing counters word/row/win.
REQ-026 In RUN with hold=0, the block SHALL issue one read per cycle: sram_rd_en=1, sram_addr = base + win*WIN_STEP + row*ROW_PITCH + word.
REQ-027 Counter order SHALL be word (0..ROW_WORDS-1) innermost, then row (0..KROWS-1), then win (0..NUM_WIN-1), each wrapping to 0 when it passes its limit.
REQ-028 In RUN with hold=1, sram_rd_en SHALL be 0 and the counters SHALL hold; reads already in flight SHALL still be delivered.
REQ-029 After the read at word=ROW_WORDS-1, row=KROWS-1, win=NUM_WIN-1, the FSM SHALL go RUN->DRAIN.
REQ-030 The FSM SHALL go DRAIN->DONE once the last beat has appeared on valid_out.
REQ-031 The FSM SHALL go DONE->IDLE after one cycle.
REQ-032 Read pipeline: act_out SHALL register sram_rdata, so valid_out follows sram_rd_en by exactly 2 cycles.
REQ-033 final_out SHALL follow the read tagged last-of-window (word=ROW_WORDS-1, row=KROWS-1) by the same 2 cycles.
REQ-034 act_out SHALL hold its last value when valid_out=0.
REQ-035 valid_skew[0] SHALL equal valid_out and valid_skew[i] SHALL equal valid_skew[i-1] delayed one cycle; final_skew SHALL behave the same way relative to final_out.
REQ-036 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE and DONE.
REQ-037 done SHALL be 1 only in the DONE state.
REQ-038 start while the FSM is not in IDLE SHALL be ignored; start in the same cycle as DONE SHALL be ignored.
REQ-039 Address arithmetic SHALL wrap modulo 2^ADDR_W with no error flag.
REQ-040 final_out SHALL assert exactly NUM_WIN times per run.
REQ-041 valid_out SHALL assert exactly ROW_WORDS*KROWS*NUM_WIN times per run.

Reset
REQ-042 Asserting reset at any time SHALL immediately force: FSM=IDLE, all counters 0, sram_rd_en=0, sram_addr=0, act_out=0, valid_out=0, final_out=0, valid_skew=0, final_skew=0, busy=0, done=0.
REQ-043 A run interrupted by reset SHALL NOT resume; a new start is required.

Verification
REQ-044 Defaults, base_addr=0, start at edge k, hold=0 -> sram_rd_en high cycles k+1..k+144; addresses 0..11, 264..275, 528..539, then 4..15, and so on; valid_out high k+3..k+146; final_out on beats 36/72/108/144; done at k+147.
REQ-045 Same run with hold=1 for 5 cycles mid-row -> address sequence unchanged, valid_out has a matching 5-cycle gap, 144 beats total, done delayed 5 cycles.
REQ-046 Check the skew chains during the default run -> valid_skew[7] rises at k+10, and final_skew[7] of the last beat falls at k+154.
REQ-047 base_addr=2040 -> addresses wrap modulo 2048 (2047 is followed by 0).
REQ-048 reset asserted at beat 50 -> all outputs 0 in the same cycle; after release, busy stays 0 until a new start arrives.
REQ-049 start pulsed during RUN and during DONE -> no effect; exactly one done pulse per accepted start.
